// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FIFO size defaults and
// the encoding of the transmit-issue state machine.
package uart_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO feeding the UART transmitter. Pointers carry one
// extra wrap bit so that full and empty are distinguishable without a
// separate occupancy register. Writes arriving while full are dropped and
// latched into a sticky overflow flag.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         ovf_clr,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since empty guards every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, wrapping naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow: a dropped write wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side transmit queue for a UART. Bytes written by the host are
// buffered in uart_sync_fifo and handed one at a time to the transmitter
// through a registered data byte and a one-cycle start pulse.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_IDLE      | no frame in flight; pops the head as soon as one exists
//   ST_ISSUE     | tx_newd high for this single cycle, tx_done ignored
//   ST_WAIT_DONE | frame in flight; tx_done returns to ST_IDLE
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_newd,
    input  logic                         tx_done,
    output logic                         busy
);

    tx_state_t         state;
    logic              pop;
    logic [DATA_W-1:0] head;

    // The head leaves the queue the moment it is captured into tx_data, so
    // count never includes the byte currently being transmitted.
    assign pop = (state == ST_IDLE) && !empty;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_clr  (ovf_clr),
        .overflow (overflow)
    );

    // Issue sequencer: capture head, pulse start, hold until frame done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tx_newd <= 1'b0;
            busy    <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_newd <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_data <= head;
                        tx_newd <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of the transmit path is
// compared against every output each cycle, and directed scenarios pin
// latencies, ordering and overflow behaviour with literal expectations.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              wr_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              ovf_clr = 1'b0;
    logic              tx_done = 1'b0;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DATA_W-1:0] tx_data;
    logic              tx_newd;
    logic              busy;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_newd  (tx_newd),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    int          newd_cyc[$];
    logic [7:0]  newd_byte[$];

    // Model state: stored bytes, byte in flight, start pulse, sticky flag.
    logic [7:0]  m_q[$];
    logic [7:0]  m_data = '0;
    logic        m_busy = 1'b0;
    logic        m_newd = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_pop;
    logic        m_drop;
    logic        m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model update on each rising edge, then per-cycle comparison.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_q.delete();
                m_data = '0;
                m_busy = 1'b0;
                m_newd = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                m_pop  = !m_busy && (m_q.size() > 0);
                m_done = m_busy && !m_newd && tx_done;
                m_drop = wr_en && (m_q.size() == DEPTH);
                if (m_pop) m_data = m_q.pop_front();
                if (wr_en && !m_drop) m_q.push_back(wr_data);
                if (m_drop) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
                m_newd = m_pop;
                if (m_pop) m_busy = 1'b1;
                else if (m_done) m_busy = 1'b0;
            end
            #1;
            check("cyc_tx_newd",  tx_newd,  m_newd);
            check("cyc_busy",     busy,     m_busy);
            check("cyc_tx_data",  tx_data,  m_data);
            check("cyc_count",    count,    m_q.size());
            check("cyc_full",     full,     m_q.size() == DEPTH);
            check("cyc_empty",    empty,    m_q.size() == 0);
            check("cyc_overflow", overflow, m_ovf);
            if (tx_newd === 1'b1) begin
                newd_cyc.push_back(cyc);
                newd_byte.push_back(tx_data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic clear_log();
        newd_cyc.delete();
        newd_byte.delete();
    endtask

    task automatic wait_newd(input int idx, output int c, output logic [7:0] b);
        int n;
        n = 0;
        while (newd_cyc.size() <= idx && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (newd_cyc.size() > idx) begin
            c = newd_cyc[idx];
            b = newd_byte[idx];
        end else begin
            total++;
            $display("FAIL wait_newd_%0d: got no tx_newd within 200 cycles, expected one", idx);
            c = -1000;
            b = 'x;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"},    empty,    1);
        check({tag, "_full"},     full,     0);
        check({tag, "_count"},    count,    0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_tx_newd"},  tx_newd,  0);
        check({tag, "_tx_data"},  tx_data,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int d;
        logic [7:0] b;

        d = 0;
        rst = 1'b0;
        repeat (2) step();
        check_reset_values("por");
        rst = 1'b1;
        step();

        // Single byte into an idle empty FIFO.
        clear_log();
        c = cyc;
        write_byte(8'hA5);
        wait_newd(0, n, b);
        check("t1_latency", n - c, 2);
        check("t1_data", b, 8'hA5);
        while (cyc < n + 3) step();
        check("t1_busy_before_done", busy, 1);
        pulse_done();
        check("t1_busy_after_done", busy, 0);

        // Three back-to-back bytes, each frame completing 10 cycles after start.
        clear_log();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            wait_newd(i, n, b);
            check("t2_byte", b, i + 1);
            if (i > 0) check("t2_gap", n - d, 2);
            while (cyc < n + 10) step();
            d = cyc;
            pulse_done();
        end

        // tx_done in IDLE, then tx_done during the start-pulse cycle.
        clear_log();
        repeat (2) step();
        pulse_done();
        repeat (4) step();
        check("t5_no_newd", newd_cyc.size(), 0);
        check("t5_busy_idle", busy, 0);
        check("t5_empty_idle", empty, 1);
        write_byte(8'h55);
        step();
        check("t5_issue_newd", tx_newd, 1);
        pulse_done();
        check("t5_done_in_issue_ignored", busy, 1);
        pulse_done();
        check("t5_done_in_wait", busy, 0);

        // Fill to full with one byte in flight, overflow, clear, drain.
        clear_log();
        for (int i = 0; i < 17; i++) begin
            b = 8'(16 + i);
            write_byte(b);
        end
        check("t3_count16", count, 16);
        check("t3_full", full, 1);
        check("t3_no_ovf_yet", overflow, 0);
        write_byte(8'hEE);
        check("t3_ovf_set", overflow, 1);
        check("t3_count_after_drop", count, 16);
        ovf_clr = 1'b1;
        write_byte(8'hEF);
        ovf_clr = 1'b0;
        check("t3_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_clr", overflow, 0);
        for (int i = 0; i < 17; i++) begin
            wait_newd(i, n, b);
            check("t3_order", b, 16 + i);
            step();
            step();
            pulse_done();
        end
        check("t3_drained", empty, 1);

        // Write coinciding with a pop at count 5.
        clear_log();
        for (int i = 0; i < 6; i++) begin
            b = 8'(8'h31 + i);
            write_byte(b);
        end
        check("t4_count_before", count, 5);
        repeat (2) step();
        pulse_done();
        write_byte(8'h37);
        check("t4_count_same", count, 5);
        check("t4_newd", tx_newd, 1);
        check("t4_data", tx_data, 8'h32);
        for (int i = 1; i < 7; i++) begin
            wait_newd(i, n, b);
            check("t4_order", b, 8'h31 + i);
            step();
            step();
            pulse_done();
        end

        // Reset while a frame is in flight with 4 bytes queued.
        clear_log();
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'h41 + i);
            write_byte(b);
        end
        repeat (3) step();
        check("t6_busy_before", busy, 1);
        check("t6_count_before", count, 4);
        rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        step();
        step();
        rst = 1'b1;
        clear_log();
        repeat (6) step();
        check("t6_no_newd_after_release", newd_cyc.size(), 0);
        check("t6_empty_after_release", empty, 1);
        c = cyc;
        write_byte(8'h77);
        wait_newd(0, n, b);
        check("t6_latency", n - c, 2);
        check("t6_data", b, 8'h77);
        step();
        pulse_done();
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
